seg_display_scan: RTL and testbench

//  Parametrised N-digit multiplexed 7-segment driver for score/level display. Successor to the 4-digit scanner.

---
 rtl/seg_display_scan_pkg.sv | 29 ++
 rtl/seg_display_scan_seg7_decode.sv | 34 +++
 rtl/seg_display_scan.sv | 208 ++++++++++++++++++++
 tb/tb_seg_display_scan.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: active-high glyphs
// (bit order g..a), decimal-point bit position and the per-slot scan states.
package seg_display_scan_pkg;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam int         DP_BIT      = 7;

    typedef enum logic {
        SCAN_DEAD = 1'b0,
        SCAN_ON   = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_display_scan_seg7_decode.sv
// Combinational nibble to active-high 7-segment glyph; A-F blank unless hex_en.
module seg_display_scan_seg7_decode
    import seg_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] glyph
);

    // Glyph lookup; letters are suppressed when hex display is disabled.
    always_comb begin
        glyph = GLYPH_BLANK;
        case (nibble)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = hex_en ? GLYPH_A : GLYPH_BLANK;
            4'hB:    glyph = hex_en ? GLYPH_B : GLYPH_BLANK;
            4'hC:    glyph = hex_en ? GLYPH_C : GLYPH_BLANK;
            4'hD:    glyph = hex_en ? GLYPH_D : GLYPH_BLANK;
            4'hE:    glyph = hex_en ? GLYPH_E : GLYPH_BLANK;
            4'hF:    glyph = hex_en ? GLYPH_F : GLYPH_BLANK;
            default: glyph = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_display_scan.sv
// N-digit multiplexed 7-segment driver: prescaled scan with dead time, frame-atomic
// value updates, leading-zero blanking, per-digit decimal point and blink.
module seg_display_scan
    import seg_display_scan_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SLOT_TICKS     = 4,
    parameter int DEAD_TICKS     = 1,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blink_in,
    input  logic                  load,
    input  logic                  hex_en,
    input  logic                  lz_blank,
    output logic                  upd_pending,
    output logic                  frame_done,
    output logic [7:0]            segment,
    output logic [N_DIGITS-1:0]   an
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW = $clog2(SLOT_TICKS);
    localparam int DW = $clog2(N_DIGITS);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [SW-1:0]       SLOT_LAST  = SW'(SLOT_TICKS - 1);
    localparam logic [SW-1:0]       DEAD_LIM   = SW'(DEAD_TICKS);
    localparam logic [DW-1:0]       DIG_LAST   = DW'(N_DIGITS - 1);
    localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] AN_INV     = {N_DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [7:0]          SEG_INV    = {8{SEG_ACTIVE_LOW != 0}};
    localparam scan_state_e         STATE_RST  = (DEAD_TICKS > 0) ? SCAN_DEAD : SCAN_ON;

    logic [PW-1:0]         presc_r;
    logic [SW-1:0]         slot_r;
    logic [DW-1:0]         scan_r;
    scan_state_e           state_r;
    logic                  frame_done_r;
    logic [BW-1:0]         frame_cnt_r;
    logic                  blink_phase_r;
    logic [4*N_DIGITS-1:0] act_digits_r;
    logic [N_DIGITS-1:0]   act_dp_r;
    logic [N_DIGITS-1:0]   act_blink_r;
    logic [4*N_DIGITS-1:0] pend_digits_r;
    logic [N_DIGITS-1:0]   pend_dp_r;
    logic [N_DIGITS-1:0]   pend_blink_r;
    logic                  upd_pending_r;
    logic [N_DIGITS-1:0]   an_r;
    logic [7:0]            segment_r;

    logic                  tick_s;
    logic                  slot_wrap_s;
    logic                  boundary_s;
    logic                  boundary_nxt_s;
    logic [PW-1:0]         presc_nxt_s;
    logic [SW-1:0]         slot_nxt_s;
    logic [DW-1:0]         scan_nxt_s;
    logic [DW-1:0]         digit_idx_s;
    logic [3:0]            nibble_s;
    logic [6:0]            glyph_s;
    logic [N_DIGITS-1:0]   lz_mask_s;
    logic                  blank_s;
    logic                  blink_off_s;
    logic [7:0]            seg_int_s;
    logic [N_DIGITS-1:0]   an_int_s;

    // Next-state of the scan counters; the boundary is predicted one cycle
    // early so frame_done can be registered yet coincide with the wrap cycle.
    always_comb begin
        tick_s      = (presc_r == PRESC_LAST);
        presc_nxt_s = tick_s ? {PW{1'b0}} : presc_r + PW'(1'b1);
        slot_wrap_s = tick_s && (slot_r == SLOT_LAST);
        if (slot_wrap_s) begin
            slot_nxt_s = {SW{1'b0}};
        end else if (tick_s) begin
            slot_nxt_s = slot_r + SW'(1'b1);
        end else begin
            slot_nxt_s = slot_r;
        end
        if (slot_wrap_s) begin
            scan_nxt_s = (scan_r == DIG_LAST) ? {DW{1'b0}} : scan_r + DW'(1'b1);
        end else begin
            scan_nxt_s = scan_r;
        end
        boundary_s     = slot_wrap_s && (scan_r == DIG_LAST);
        boundary_nxt_s = (presc_nxt_s == PRESC_LAST) && (slot_nxt_s == SLOT_LAST)
                         && (scan_nxt_s == DIG_LAST);
    end

    // Prescaler, slot/digit scan FSM and frame_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r      <= {PW{1'b0}};
            slot_r       <= {SW{1'b0}};
            scan_r       <= {DW{1'b0}};
            state_r      <= STATE_RST;
            frame_done_r <= 1'b0;
        end else begin
            presc_r      <= presc_nxt_s;
            slot_r       <= slot_nxt_s;
            scan_r       <= scan_nxt_s;
            frame_done_r <= boundary_nxt_s;
            case (state_r)
                SCAN_DEAD: state_r <= (slot_nxt_s < DEAD_LIM) ? SCAN_DEAD : SCAN_ON;
                SCAN_ON:   state_r <= (slot_nxt_s < DEAD_LIM) ? SCAN_DEAD : SCAN_ON;
                default:   state_r <= STATE_RST;
            endcase
        end
    end

    // Shadow/active registers: active only changes at a frame boundary so a
    // frame never mixes two loads; a load on the boundary itself bypasses pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_digits_r  <= {(4*N_DIGITS){1'b0}};
            act_dp_r      <= {N_DIGITS{1'b0}};
            act_blink_r   <= {N_DIGITS{1'b0}};
            pend_digits_r <= {(4*N_DIGITS){1'b0}};
            pend_dp_r     <= {N_DIGITS{1'b0}};
            pend_blink_r  <= {N_DIGITS{1'b0}};
            upd_pending_r <= 1'b0;
        end else if (load && boundary_s) begin
            act_digits_r  <= digits_in;
            act_dp_r      <= dp_in;
            act_blink_r   <= blink_in;
            upd_pending_r <= 1'b0;
        end else if (load) begin
            pend_digits_r <= digits_in;
            pend_dp_r     <= dp_in;
            pend_blink_r  <= blink_in;
            upd_pending_r <= 1'b1;
        end else if (boundary_s && upd_pending_r) begin
            act_digits_r  <= pend_digits_r;
            act_dp_r      <= pend_dp_r;
            act_blink_r   <= pend_blink_r;
            upd_pending_r <= 1'b0;
        end
    end

    // Blink half-period counter, advanced once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r   <= {BW{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (boundary_s) begin
            if (frame_cnt_r == BLINK_LAST) begin
                frame_cnt_r   <= {BW{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + BW'(1'b1);
            end
        end
    end

    seg_display_scan_seg7_decode u_decode (
        .nibble (nibble_s),
        .hex_en (hex_en),
        .glyph  (glyph_s)
    );

    // Leading-zero mask, current digit selection and active-high pixel data.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run     = zero_run & (act_digits_r[4*k +: 4] == 4'h0);
            lz_mask_s[k] = zero_run & (k != 0);
        end
        digit_idx_s = DIG_LAST - scan_r;
        nibble_s    = act_digits_r[{digit_idx_s, 2'b00} +: 4];
        blank_s     = lz_blank & lz_mask_s[digit_idx_s];
        blink_off_s = blink_phase_r & act_blink_r[digit_idx_s];
        if (state_r == SCAN_ON) begin
            an_int_s             = {{(N_DIGITS-1){1'b0}}, 1'b1} << digit_idx_s;
            seg_int_s[6:0]       = (blank_s || blink_off_s) ? GLYPH_BLANK : glyph_s;
            seg_int_s[DP_BIT]    = act_dp_r[digit_idx_s] & ~blink_off_s;
        end else begin
            an_int_s             = {N_DIGITS{1'b0}};
            seg_int_s            = 8'h00;
        end
    end

    // Output registers with board polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r      <= AN_INV;
            segment_r <= SEG_INV;
        end else begin
            an_r      <= an_int_s ^ AN_INV;
            segment_r <= seg_int_s ^ SEG_INV;
        end
    end

    assign an          = an_r;
    assign segment     = segment_r;
    assign frame_done  = frame_done_r;
    assign upd_pending = upd_pending_r;

endmodule

// File: tb/tb_seg_display_scan.sv
// Scoreboard bench for seg_display_scan: expected frames are queued when values
// are loaded and compared against a whole captured scan frame.
module tb_seg_display_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blink_in = 4'b0000;
    logic        load = 1'b0;
    logic        hex_en = 1'b0;
    logic        lz_blank = 1'b0;
    logic        upd_pending;
    logic        frame_done;
    logic [7:0]  segment;
    logic [3:0]  an;

    int          n_checks = 0;
    int          n_fail = 0;
    int          fcnt;
    logic [31:0] exp_q[$];
    logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_display_scan #(
        .N_DIGITS(4), .REFRESH_DIV(2), .SLOT_TICKS(4), .DEAD_TICKS(1),
        .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
        .blink_in(blink_in), .load(load), .hex_en(hex_en), .lz_blank(lz_blank),
        .upd_pending(upd_pending), .frame_done(frame_done), .segment(segment), .an(an)
    );

    always #5 clk = ~clk;

    // Frame boundaries since reset, used to predict the blink phase.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fcnt <= 0;
        else if (frame_done) fcnt <= fcnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Expected active-low segment bytes for digits 3..0 (packed, digit k at [8k+:8]).
    function automatic logic [31:0] model(input logic [15:0] d, input logic [3:0] dp,
                                          input logic [3:0] bl, input logic hx,
                                          input logic lz, input logic ph);
        logic [31:0] r;
        logic        zrun;
        logic [3:0]  nib;
        logic [6:0]  g;
        logic [7:0]  s;
        r = 32'h0;
        zrun = 1'b1;
        for (int k = 3; k >= 0; k--) begin
            nib  = d[4*k +: 4];
            zrun = zrun && (nib == 4'h0);
            g    = (nib > 4'd9 && !hx) ? 7'h00 : glyph_tab[nib];
            if (lz && zrun && k != 0) g = 7'h00;
            s = {dp[k], g};
            if (ph && bl[k]) s = 8'h00;
            r[8*k +: 8] = ~s;
        end
        return r;
    endfunction

    task automatic wait_fd(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called at the negedge of a frame_done cycle; records the following frame.
    task automatic capture_frame(output logic [31:0] segs, output logic [31:0] on,
                                 output int dead, output logic cons,
                                 output logic pend0, output logic pend_any);
        logic [3:0] oh;
        @(negedge clk);
        load = 1'b0;
        pend0 = upd_pending;
        pend_any = upd_pending;
        segs = 32'h0;
        on = 32'h0;
        dead = 0;
        cons = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            pend_any = pend_any | upd_pending;
            if (an === 4'hF) begin
                dead++;
                if (segment !== 8'hFF) cons = 1'b0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (an[k] === 1'b0) begin
                        oh = 4'b0001 << k;
                        if (an !== ~oh) cons = 1'b0;
                        if (on[8*k +: 8] == 8'd0) segs[8*k +: 8] = segment;
                        else if (segs[8*k +: 8] !== segment) cons = 1'b0;
                        on[8*k +: 8] = on[8*k +: 8] + 8'd1;
                    end
                end
            end
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        @(negedge clk);
        for (int i = 0; i < 4 && frame_done === 1'b1; i++) @(negedge clk);
        digits_in = d;
        dp_in = dp;
        blink_in = bl;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (an !== 4'hF) begin n_fail++; $display("FAIL reset_an: got %h want f", an); end
        n_checks++; if (segment !== 8'hFF) begin n_fail++; $display("FAIL reset_seg: got %h want ff", segment); end
        n_checks++; if (upd_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pend: got %b want 0", upd_pending); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_fd: got %b want 0", frame_done); end
        @(negedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (an !== 4'hF) break;
        end
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL release_dead: first anode after %0d cycles want 3", n); end
        n_checks++; if (an !== 4'b0111) begin n_fail++; $display("FAIL release_an: got %b want 0111", an); end
        n_checks++; if (segment !== 8'hC0) begin n_fail++; $display("FAIL release_seg: got %h want c0", segment); end
    endtask

    task automatic test_decode();
        logic [31:0] segs, on, exp;
        int dead;
        logic cons, p0, pa, ok;
        do_load(16'h1234, 4'b0000, 4'b0000);
        exp_q.push_back(model(16'h1234, 4'b0000, 4'b0000, hex_en, lz_blank, 1'b0));
        n_checks++; if (upd_pending !== 1'b1) begin n_fail++; $display("FAIL decode_pend: got %b want 1", upd_pending); end
        wait_fd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL decode_fd_timeout: no frame_done"); end
        capture_frame(segs, on, dead, cons, p0, pa);
        exp = exp_q.pop_front();
        n_checks++; if (segs !== exp) begin n_fail++; $display("FAIL decode_segs: got %h want %h", segs, exp); end
        n_checks++; if (on !== 32'h06060606) begin n_fail++; $display("FAIL decode_on_time: got %h want 06060606", on); end
        n_checks++; if (dead != 8) begin n_fail++; $display("FAIL decode_dead: got %0d want 8", dead); end
        n_checks++; if (cons !== 1'b1) begin n_fail++; $display("FAIL decode_steady: got %b want 1", cons); end
        n_checks++; if (p0 !== 1'b0) begin n_fail++; $display("FAIL decode_pend_clr: got %b want 0", p0); end
    endtask

    task automatic test_atomic();
        logic [31:0] segs, on, exp;
        int dead;
        logic cons, p0, pa, ok;
        wait_fd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL atomic_fd_timeout: no frame_done"); end
        repeat (8) @(negedge clk);
        do_load(16'h1111, 4'b0000, 4'b0000);
        n_checks++; if (upd_pending !== 1'b1) begin n_fail++; $display("FAIL atomic_pend1: got %b want 1", upd_pending); end
        repeat (4) @(negedge clk);
        do_load(16'h2222, 4'b0000, 4'b0000);
        exp_q.push_back(model(16'h2222, 4'b0000, 4'b0000, hex_en, lz_blank, 1'b0));
        n_checks++; if (upd_pending !== 1'b1) begin n_fail++; $display("FAIL atomic_pend2: got %b want 1", upd_pending); end
        wait_fd(ok);
        n_checks++; if (upd_pending !== 1'b1) begin n_fail++; $display("FAIL atomic_pend_at_fd: got %b want 1", upd_pending); end
        capture_frame(segs, on, dead, cons, p0, pa);
        exp = exp_q.pop_front();
        n_checks++; if (segs !== exp) begin n_fail++; $display("FAIL atomic_segs: got %h want %h", segs, exp); end
        n_checks++; if (cons !== 1'b1) begin n_fail++; $display("FAIL atomic_steady: got %b want 1", cons); end
        n_checks++; if (p0 !== 1'b0) begin n_fail++; $display("FAIL atomic_pend_clr: got %b want 0", p0); end
    endtask

    task automatic test_collision();
        logic [31:0] segs, on, exp;
        int dead;
        logic cons, p0, pa, ok;
        wait_fd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL coll_fd_timeout: no frame_done"); end
        digits_in = 16'h5555;
        dp_in = 4'b0000;
        blink_in = 4'b0000;
        load = 1'b1;
        exp_q.push_back(model(16'h5555, 4'b0000, 4'b0000, hex_en, lz_blank, 1'b0));
        capture_frame(segs, on, dead, cons, p0, pa);
        exp = exp_q.pop_front();
        n_checks++; if (pa !== 1'b0) begin n_fail++; $display("FAIL coll_pend: got %b want 0", pa); end
        n_checks++; if (segs !== exp) begin n_fail++; $display("FAIL coll_segs: got %h want %h", segs, exp); end
    endtask

    task automatic test_lz_hex();
        logic [31:0] segs, on, exp;
        int dead;
        logic cons, p0, pa, ok;
        lz_blank = 1'b1;
        hex_en = 1'b0;
        do_load(16'h00A0, 4'b0000, 4'b0000);
        exp_q.push_back(model(16'h00A0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0));
        wait_fd(ok);
        capture_frame(segs, on, dead, cons, p0, pa);
        exp = exp_q.pop_front();
        n_checks++; if (segs !== exp) begin n_fail++; $display("FAIL lz_nohex_segs: got %h want %h", segs, exp); end
        n_checks++; if (on !== 32'h06060606) begin n_fail++; $display("FAIL lz_on_time: got %h want 06060606", on); end
        hex_en = 1'b1;
        exp_q.push_back(model(16'h00A0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0));
        wait_fd(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL lz_fd_timeout: no frame_done"); end
        capture_frame(segs, on, dead, cons, p0, pa);
        exp = exp_q.pop_front();
        n_checks++; if (segs !== exp) begin n_fail++; $display("FAIL lz_hex_segs: got %h want %h", segs, exp); end
    endtask

    task automatic test_blink();
        logic [31:0] segs, on, exp;
        int dead;
        logic cons, p0, pa, ok, ph;
        lz_blank = 1'b0;
        hex_en = 1'b0;
        do_load(16'h1234, 4'b0001, 4'b0001);
        for (int f = 0; f < 4; f++) begin
            wait_fd(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL blink_fd_timeout: frame %0d", f); end
            ph = (((fcnt + 1) / 2) % 2) == 1;
            exp_q.push_back(model(16'h1234, 4'b0001, 4'b0001, 1'b0, 1'b0, ph));
            capture_frame(segs, on, dead, cons, p0, pa);
            exp = exp_q.pop_front();
            n_checks++; if (segs !== exp) begin n_fail++; $display("FAIL blink_segs: frame %0d got %h want %h", f, segs, exp); end
            n_checks++; if (cons !== 1'b1) begin n_fail++; $display("FAIL blink_steady: frame %0d got %b want 1", f, cons); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        test_reset();
        test_decode();
        test_atomic();
        test_collision();
        test_lz_hex();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
